// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state type and counter-width helper for the serial adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width: $clog2(n), never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_digit.sv
// rtl/adder_digit.sv - combinational W-bit ripple slice reused once per digit cycle
module adder_digit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_serial.sv
// rtl/adder_serial.sv - digit-serial add/sub, LSB digit first; flags under ADDER_SERIAL_FLAGS_EN
module adder_serial
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
        $error("adder_serial: WIDTH must be a positive multiple of DIGIT");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [DIGIT-1:0]       dg_sum;
    logic                   dg_cout;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_shifted;
    logic                   last_digit;

    adder_digit #(.W(DIGIT)) u_digit (
        .a    (a_sh_q[DIGIT-1:0]),
        .b    (b_sh_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (dg_sum),
        .cout (dg_cout)
    );

    // New digit enters at the MSB end; after N digits the LSB digit has reached bit 0.
    assign sum_cat     = {dg_sum, sum_q};
    assign sum_shifted = sum_cat[WIDTH+DIGIT-1:DIGIT];
    assign last_digit  = (state_q == RUN) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                carry_d = dg_cout;
                sum_d   = sum_shifted;
                cnt_d   = cnt_q + CW'(1);
                if (last_digit) begin
                    cnt_d   = '0;
                    cout_d  = dg_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef ADDER_SERIAL_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    // On the last digit the low slice bits of the shifters hold the operand MSBs.
    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (last_digit) begin
            ovf_d  = (a_sh_q[DIGIT-1] == b_sh_q[DIGIT-1]) && (dg_sum[DIGIT-1] != a_sh_q[DIGIT-1]);
            zero_d = (sum_shifted == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_adder_serial.sv
// tb/tb_adder_serial.sv - table, random and corner-sequence checks for adder_serial
module tb_adder_serial;

`ifdef ADDER_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_cmp  = 0;
    int n_fail = 0;

    adder_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical meaning of add/sub.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [15:0] s, output logic co,
                                  output logic ov, output logic z);
        int ua, ub, sa, sb, ru, rs, c;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        c  = mcin ? 1 : 0;
        if (!msub) begin
            ru = ua + ub + c;
            rs = sa + sb + c;
            co = (ru > 65535);
        end else begin
            ru = ua - ub - c;
            rs = sa - sb - c;
            co = (ru >= 0);
        end
        s  = ru[15:0];
        ov = FLAGS && ((rs > 32767) || (rs < -32768));
        z  = FLAGS && (s == 16'h0000);
    endfunction

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub,
                         input int hold, input bit poke,
                         output logic [15:0] rs, output logic rco,
                         output logic rov, output logic rz);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_before_issue", in_ready, 1);
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        chk("in_ready_in_run", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = (poke && lat == 1);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, 4);
        rs = sum; rco = cout; rov = ovf; rz = zero;
        for (int i = 0; i < hold; i++) begin
            in_valid = poke;
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_sum", sum, rs);
            chk("hold_cout", cout, rco);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_handshake", in_ready, 1);
        chk("out_valid_after_handshake", out_valid, 0);
        chk("sum_kept_after_handshake", sum, rs);
    endtask

    initial begin
        logic [15:0] gs, es;
        logic        gco, gov, gz, eco, eov, ez;
        logic [15:0] ra, rb;
        logic        rc, rsb;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #3;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_zero", zero, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, (i == 0) ? 3 : 0, (i == 0),
                  gs, gco, gov, gz);
            chk("vec_sum", gs, vecs[i].s);
            chk("vec_cout", gco, vecs[i].co);
            chk("vec_ovf", gov, FLAGS & vecs[i].ov);
            chk("vec_zero", gz, FLAGS & vecs[i].z);
        end

        for (int k = 0; k < 30; k++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rsb = 1'($urandom);
            if (k % 7 == 0) rb = ra;
            model(ra, rb, rc, rsb, es, eco, eov, ez);
            do_op(ra, rb, rc, rsb, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)),
                  gs, gco, gov, gz);
            chk("rand_sum", gs, es);
            chk("rand_cout", gco, eco);
            chk("rand_ovf", gov, eov);
            chk("rand_zero", gz, ez);
        end

        // Abort during digit 2 of a run, then confirm a clean restart.
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_zero", zero, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0, gs, gco, gov, gz);
        chk("after_abort_sum", gs, 16'h0002);
        chk("after_abort_cout", gco, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
